divider_sched: RTL
==================

# divider_sched

Round-robin scheduler that shares one `divider` instance (DIVIDEND/DIVISOR-bit, combinational, multicycle-constrained) among NREQ requesters.
- Arbitrates requests and captures the granted requester's operands into registers that drive the divider.
- Holds those operands stable for LAT cycles, then returns quotient, remainder, requester id and a divide-by-zero flag.
- Sits between the requester blocks and the single shared divider datapath.

## Interface
Parameters:
- DIVIDEND, 16, dividend and quotient width
- DIVISOR, 8, divisor and remainder width
- NREQ, 4, number of requesters (≥2)
- LAT, 2, cycles the divider inputs are held before the result is sampled (≥1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request level
- req_dividend  in  NREQ*DIVIDEND  packed dividends, requester i at [i*DIVIDEND +: DIVIDEND]
- req_divisor  in  NREQ*DIVISOR  packed divisors, requester i at [i*DIVISOR +: DIVISOR]
- gnt  out  NREQ  one-hot grant, combinational, valid only in IDLE
- busy  out  1  high whenever state ≠ IDLE
- div_dividend  out  DIVIDEND  registered operand to the divider
- div_divisor  out  DIVISOR  registered operand to the divider
- div_quotient  in  DIVIDEND  divider quotient
- div_remainder  in  DIVISOR  divider remainder
- valid_out  out  1  one-cycle result strobe
- id_out  out  $clog2(NREQ)  index of the requester that owns the result
- quotient_out  out  DIVIDEND  registered quotient
- remainder_out  out  DIVISOR  registered remainder
- dbz_out  out  1  divide-by-zero flag for this result

## Operation
States:
- **IDLE**
  - `gnt` selects the first requester with `req` high, searching from `ptr` upward with wrap.
  - On a grant edge: latch that requester's operands into `div_dividend`/`div_divisor`, latch `id`, and set `ptr` = granted index + 1 (mod NREQ).
  - Next state: BUSY if the latched divisor ≠ 0, else DONE with the dbz path taken.
- **BUSY**
  - Counter loads LAT−1 on entry and decrements each cycle.
  - At count 0: register `div_quotient`/`div_remainder` into the outputs; next state DONE.
- **DONE**
  - `valid_out` = 1 for exactly one cycle; `id_out` and the data outputs are valid.
  - Next state is always IDLE.

Rules:
- A requester holds `req` and its operands until it sees `gnt`. `gnt` is the sole sample point.
- Dropping `req` before `gnt` withdraws the request; no error results.
- Divisor = 0: the divider is not waited on. Result is quotient = all ones, remainder = 0, `dbz_out` = 1.
- `gnt` is 0 outside IDLE and while `rst` is high. Requests arriving in BUSY/DONE wait; nothing is queued internally.
- Data outputs keep their last value after DONE; only `valid_out` returns to 0.
- Reset mid-operation: return to IDLE, drop the pending result, `ptr` = 0, no `valid_out`.
- Reset values: `gnt`, `busy`, `valid_out`, `dbz_out` = 0; `id_out`, `quotient_out`, `remainder_out`, `div_dividend`, `div_divisor` = 0; `ptr` = 0; state = IDLE.

## Timing
- Grant in cycle t (IDLE, combinational) → operands at the divider from t+1.
- Normal result: `valid_out` in cycle t+LAT+1.
- Divide-by-zero result: `valid_out` in cycle t+1.
- The DONE cycle is the IDLE-return cycle, so the earliest next grant is t+LAT+2 (normal) or t+2 (dbz).
- Sustained throughput is one operation per LAT+2 cycles.
- `div_dividend`/`div_divisor` change only on a grant edge. The divider path is constrained as an LAT-cycle multicycle path.

## Test plan
- Single request: requester 2 sends 100/7, LAT=2, granted at t → `valid_out` at t+3, `id_out`=2, quotient 14, remainder 2, `dbz_out`=0.
- Fairness after reset: all four requesters held high → grants occur in order 0,1,2,3,0. Each result's `id_out` matches its grant; spacing is 4 cycles.
- Divide by zero: requester 1 sends 500/0 → `valid_out` one cycle after grant, quotient 0xFFFF, remainder 0, `dbz_out`=1. Next grant comes 2 cycles after the previous grant.
- Pointer wrap and skip: `ptr`=3, only requesters 1 and 3 active → grant 3, then 1; requester 0 is never granted.
- Reset in BUSY: `rst` pulses one cycle after a grant → no `valid_out` follows, all outputs 0, and the next grant goes to the lowest active index.
- Withdrawal: requester 0 drops `req` while BUSY serves requester 3 → no grant to 0 afterwards and no spurious `valid_out`. Every result is also cross-checked as `quotient_out*divisor + remainder_out == dividend` over random operands.

Source files
------------

// File: rtl/divider_sched.sv
// divider_sched: round-robin scheduler that time-shares one combinational,
// multicycle-constrained divider among NREQ requesters.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req[NREQ]                    per-requester request level
//   req_dividend / req_divisor   packed operands, requester i in slice i
//   gnt[NREQ]                    one-hot grant (combinational, IDLE only)
//   busy                         high whenever not IDLE
//   div_dividend / div_divisor   registered operands to the shared divider
//   div_quotient / div_remainder divider results
//   valid_out                    one-cycle result strobe
//   id_out                       requester that owns the result
//   quotient_out / remainder_out registered results, held after the strobe
//   dbz_out                      divide-by-zero flag for the result
module divider_sched #(
  parameter int DIVIDEND = 16,
  parameter int DIVISOR  = 8,
  parameter int NREQ     = 4,
  parameter int LAT      = 2,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DIVIDEND-1:0] req_dividend,
  input  logic [NREQ*DIVISOR-1:0]  req_divisor,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic [DIVIDEND-1:0]      div_dividend,
  output logic [DIVISOR-1:0]       div_divisor,
  input  logic [DIVIDEND-1:0]      div_quotient,
  input  logic [DIVISOR-1:0]       div_remainder,
  output logic                     valid_out,
  output logic [IDW-1:0]           id_out,
  output logic [DIVIDEND-1:0]      quotient_out,
  output logic [DIVISOR-1:0]       remainder_out,
  output logic                     dbz_out
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [IDW-1:0]      id_out_q, id_out_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DIVIDEND-1:0] dd_q, dd_d;
  logic [DIVISOR-1:0]  dv_q, dv_d;
  logic [DIVIDEND-1:0] quot_q, quot_d;
  logic [DIVISOR-1:0]  rem_q, rem_d;
  logic                dbz_q, dbz_d;

  logic                found;
  logic [IDW-1:0]      gnt_idx;
  int                  j;
  logic [DIVIDEND-1:0] sel_dividend;
  logic [DIVISOR-1:0]  sel_divisor;

  // Round-robin search starting at ptr_q, wrapping past NREQ-1.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    gnt     = '0;
    j       = 0;
    if (state_q == IDLE && !rst) begin
      for (int k = 0; k < NREQ; k++) begin
        j = int'(ptr_q) + k;
        if (j >= NREQ) j = j - NREQ;
        if (!found && req[j]) begin
          found   = 1'b1;
          gnt_idx = IDW'(j);
        end
      end
    end
    if (found) gnt[gnt_idx] = 1'b1;
  end

  assign sel_dividend = req_dividend[int'(gnt_idx)*DIVIDEND +: DIVIDEND];
  assign sel_divisor  = req_divisor[int'(gnt_idx)*DIVISOR +: DIVISOR];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    id_out_d = id_out_q;
    cnt_d    = cnt_q;
    dd_d     = dd_q;
    dv_d     = dv_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dbz_d    = dbz_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          dd_d  = sel_dividend;
          dv_d  = sel_divisor;
          id_d  = gnt_idx;
          ptr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
          if (sel_divisor == '0) begin
            // Zero divisor: skip the divider, result is ready next cycle.
            quot_d   = '1;
            rem_d    = '0;
            dbz_d    = 1'b1;
            id_out_d = gnt_idx;
            state_d  = DONE;
          end else begin
            cnt_d   = CW'(LAT-1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // Operands have now been stable for LAT cycles.
        if (cnt_q == '0) begin
          quot_d   = div_quotient;
          rem_d    = div_remainder;
          dbz_d    = 1'b0;
          id_out_d = id_q;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      id_q     <= '0;
      id_out_q <= '0;
      cnt_q    <= '0;
      dd_q     <= '0;
      dv_q     <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      id_out_q <= id_out_d;
      cnt_q    <= cnt_d;
      dd_q     <= dd_d;
      dv_q     <= dv_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign valid_out     = (state_q == DONE);
  assign div_dividend  = dd_q;
  assign div_divisor   = dv_q;
  assign id_out        = id_out_q;
  assign quotient_out  = quot_q;
  assign remainder_out = rem_q;
  assign dbz_out       = dbz_q;

endmodule
